// File: rtl/operand_read_stage.sv
// operand_read_stage
//   Register-read stage between the reservation stations and the FUs. Each
//   issue channel drives its PRF read ports, resolves both sources (zero
//   register / unused -> 0, same-cycle writeback bypass, else PRF data) and
//   latches the result into a one-entry output register with valid/ready
//   toward its FU. Channels are independent lanes.
// Ports:
//   clk, rst_n (sync, active low), flush
//   issue_valid/ready/ps1/ps2/use1/use2/payload   : per-channel issue side
//   prf_re1/re2/raddr1/raddr2, prf_rdata1/rdata2   : PRF read ports (comb data)
//   wb_valid/wb_pd/wb_data                         : writeback broadcast
//   fu_valid/ready/op1/op2/payload                 : per-channel FU side

module operand_read_lane #(
  parameter int NUM_WB    = 3,
  parameter int PREG_W    = 7,
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  logic [PREG_W-1:0]                  ps1,
  input  logic [PREG_W-1:0]                  ps2,
  input  logic                               use1,
  input  logic                               use2,
  input  logic [PAYLOAD_W-1:0]               payload,
  output logic                               re1,
  output logic                               re2,
  output logic [PREG_W-1:0]                  raddr1,
  output logic [PREG_W-1:0]                  raddr2,
  input  logic [XLEN-1:0]                    rdata1,
  input  logic [XLEN-1:0]                    rdata2,
  input  logic [NUM_WB-1:0]                  wb_valid,
  input  logic [NUM_WB-1:0][PREG_W-1:0]      wb_pd,
  input  logic [NUM_WB-1:0][XLEN-1:0]        wb_data,
  output logic                               fu_valid,
  input  logic                               fu_ready,
  output logic [XLEN-1:0]                    fu_op1,
  output logic [XLEN-1:0]                    fu_op2,
  output logic [PAYLOAD_W-1:0]               fu_payload
);
  typedef struct packed {
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t entry, entry_nxt;
  logic   vld;
  logic   accept;

  // Scan ports high to low so the lowest-index match is the last to land.
  // Zero register / unused source overrides everything, so stale PRF data
  // on a disabled read never leaks through.
  function automatic logic [XLEN-1:0] resolve(input logic src_use,
                                              input logic [PREG_W-1:0] ps,
                                              input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] r;
    r = rdata;
    for (int i = NUM_WB-1; i >= 0; i--)
      if (wb_valid[i] && wb_pd[i] == ps) r = wb_data[i];
    if (!src_use || ps == '0) r = '0;
    return r;
  endfunction

  assign re1    = issue_valid && use1 && (ps1 != '0);
  assign re2    = issue_valid && use2 && (ps2 != '0);
  assign raddr1 = re1 ? ps1 : '0;
  assign raddr2 = re2 ? ps2 : '0;

  // Ready looks only at the output register and fu_ready, never issue_valid.
  assign issue_ready = !vld || fu_ready;
  assign accept      = issue_valid && issue_ready && !flush;

  always_comb begin
    entry_nxt.op1     = resolve(use1, ps1, rdata1);
    entry_nxt.op2     = resolve(use2, ps2, rdata2);
    entry_nxt.payload = payload;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      entry <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (accept) begin
      vld   <= 1'b1;
      entry <= entry_nxt;
    end else if (fu_ready) begin
      vld <= 1'b0;
    end
  end

  assign fu_valid   = vld;
  assign fu_op1     = entry.op1;
  assign fu_op2     = entry.op2;
  assign fu_payload = entry.payload;
endmodule

module operand_read_stage #(
  parameter int NUM_CH    = 3,
  parameter int NUM_WB    = 3,
  parameter int PREG_W    = 7,
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [NUM_CH-1:0]                  issue_valid,
  output logic [NUM_CH-1:0]                  issue_ready,
  input  logic [NUM_CH-1:0][PREG_W-1:0]      issue_ps1,
  input  logic [NUM_CH-1:0][PREG_W-1:0]      issue_ps2,
  input  logic [NUM_CH-1:0]                  issue_use1,
  input  logic [NUM_CH-1:0]                  issue_use2,
  input  logic [NUM_CH-1:0][PAYLOAD_W-1:0]   issue_payload,
  output logic [NUM_CH-1:0]                  prf_re1,
  output logic [NUM_CH-1:0]                  prf_re2,
  output logic [NUM_CH-1:0][PREG_W-1:0]      prf_raddr1,
  output logic [NUM_CH-1:0][PREG_W-1:0]      prf_raddr2,
  input  logic [NUM_CH-1:0][XLEN-1:0]        prf_rdata1,
  input  logic [NUM_CH-1:0][XLEN-1:0]        prf_rdata2,
  input  logic [NUM_WB-1:0]                  wb_valid,
  input  logic [NUM_WB-1:0][PREG_W-1:0]      wb_pd,
  input  logic [NUM_WB-1:0][XLEN-1:0]        wb_data,
  output logic [NUM_CH-1:0]                  fu_valid,
  input  logic [NUM_CH-1:0]                  fu_ready,
  output logic [NUM_CH-1:0][XLEN-1:0]        fu_op1,
  output logic [NUM_CH-1:0][XLEN-1:0]        fu_op2,
  output logic [NUM_CH-1:0][PAYLOAD_W-1:0]   fu_payload
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    operand_read_lane #(
      .NUM_WB(NUM_WB), .PREG_W(PREG_W), .XLEN(XLEN), .PAYLOAD_W(PAYLOAD_W)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .issue_valid(issue_valid[c]),
      .issue_ready(issue_ready[c]),
      .ps1        (issue_ps1[c]),
      .ps2        (issue_ps2[c]),
      .use1       (issue_use1[c]),
      .use2       (issue_use2[c]),
      .payload    (issue_payload[c]),
      .re1        (prf_re1[c]),
      .re2        (prf_re2[c]),
      .raddr1     (prf_raddr1[c]),
      .raddr2     (prf_raddr2[c]),
      .rdata1     (prf_rdata1[c]),
      .rdata2     (prf_rdata2[c]),
      .wb_valid   (wb_valid),
      .wb_pd      (wb_pd),
      .wb_data    (wb_data),
      .fu_valid   (fu_valid[c]),
      .fu_ready   (fu_ready[c]),
      .fu_op1     (fu_op1[c]),
      .fu_op2     (fu_op2[c]),
      .fu_payload (fu_payload[c])
    );
  end
endmodule

// File: tb/tb_operand_read_stage.sv
// tb_operand_read_stage
//   Directed scenarios followed by a randomized run, all checked against a
//   behavioural model of the per-channel output register.
module tb_operand_read_stage;
  localparam int NC = 3, NW = 3, PW = 7, XL = 32, PL = 32;

  logic clk = 1'b0;
  logic rst_n, flush;
  logic [NC-1:0]          issue_valid, issue_ready, issue_use1, issue_use2;
  logic [NC-1:0][PW-1:0]  issue_ps1, issue_ps2, prf_raddr1, prf_raddr2;
  logic [NC-1:0][PL-1:0]  issue_payload, fu_payload;
  logic [NC-1:0]          prf_re1, prf_re2, fu_valid, fu_ready;
  logic [NC-1:0][XL-1:0]  prf_rdata1, prf_rdata2, fu_op1, fu_op2;
  logic [NW-1:0]          wb_valid;
  logic [NW-1:0][PW-1:0]  wb_pd;
  logic [NW-1:0][XL-1:0]  wb_data;

  operand_read_stage #(.NUM_CH(NC), .NUM_WB(NW), .PREG_W(PW), .XLEN(XL), .PAYLOAD_W(PL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_ps1(issue_ps1), .issue_ps2(issue_ps2),
    .issue_use1(issue_use1), .issue_use2(issue_use2), .issue_payload(issue_payload),
    .prf_re1(prf_re1), .prf_re2(prf_re2), .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
    .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2),
    .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_data(wb_data),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_op1(fu_op1), .fu_op2(fu_op2),
    .fu_payload(fu_payload)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  // Behavioural model: what each FU should currently be holding.
  bit              m_vld [NC];
  logic [XL-1:0]   m_op1 [NC];
  logic [XL-1:0]   m_op2 [NC];
  logic [PL-1:0]   m_pay [NC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Operand value straight from the rules: zero/unused, else first matching
  // writeback port, else PRF data.
  function automatic logic [XL-1:0] ref_operand(input logic u, input logic [PW-1:0] ps,
                                                input logic [XL-1:0] rd);
    if (!u || ps == 0) return '0;
    for (int i = 0; i < NW; i++)
      if (wb_valid[i] && wb_pd[i] == ps) return wb_data[i];
    return rd;
  endfunction

  // Check combinational outputs mid-cycle, compute the model's next state,
  // take the edge, then check registered outputs.
  task automatic cycle();
    bit            n_vld [NC];
    logic [XL-1:0] n_op1 [NC];
    logic [XL-1:0] n_op2 [NC];
    logic [PL-1:0] n_pay [NC];
    #4;
    for (int c = 0; c < NC; c++) begin
      bit rdy, e1, e2;
      rdy = !m_vld[c] || fu_ready[c];
      e1  = issue_valid[c] && issue_use1[c] && issue_ps1[c] != 0;
      e2  = issue_valid[c] && issue_use2[c] && issue_ps2[c] != 0;
      chk($sformatf("issue_ready[%0d]", c), 32'(issue_ready[c]), 32'(rdy));
      chk($sformatf("prf_re1[%0d]", c), 32'(prf_re1[c]), 32'(e1));
      chk($sformatf("prf_re2[%0d]", c), 32'(prf_re2[c]), 32'(e2));
      chk($sformatf("prf_raddr1[%0d]", c), 32'(prf_raddr1[c]), e1 ? 32'(issue_ps1[c]) : 32'd0);
      chk($sformatf("prf_raddr2[%0d]", c), 32'(prf_raddr2[c]), e2 ? 32'(issue_ps2[c]) : 32'd0);
      n_vld[c] = m_vld[c]; n_op1[c] = m_op1[c]; n_op2[c] = m_op2[c]; n_pay[c] = m_pay[c];
      if (!rst_n) begin
        n_vld[c] = 0; n_op1[c] = 0; n_op2[c] = 0; n_pay[c] = 0;
      end else if (flush) begin
        n_vld[c] = 0;
      end else if (issue_valid[c] && rdy) begin
        n_vld[c] = 1;
        n_op1[c] = ref_operand(issue_use1[c], issue_ps1[c], prf_rdata1[c]);
        n_op2[c] = ref_operand(issue_use2[c], issue_ps2[c], prf_rdata2[c]);
        n_pay[c] = issue_payload[c];
      end else if (fu_ready[c]) begin
        n_vld[c] = 0;
      end
    end
    @(posedge clk); #1;
    for (int c = 0; c < NC; c++) begin
      m_vld[c] = n_vld[c]; m_op1[c] = n_op1[c]; m_op2[c] = n_op2[c]; m_pay[c] = n_pay[c];
      chk($sformatf("fu_valid[%0d]", c), 32'(fu_valid[c]), 32'(m_vld[c]));
      if (m_vld[c]) begin
        chk($sformatf("fu_op1[%0d]", c), fu_op1[c], m_op1[c]);
        chk($sformatf("fu_op2[%0d]", c), fu_op2[c], m_op2[c]);
        chk($sformatf("fu_payload[%0d]", c), fu_payload[c], m_pay[c]);
      end
    end
  endtask

  task automatic idle_inputs();
    flush = 0; issue_valid = '0; issue_use1 = '0; issue_use2 = '0;
    issue_ps1 = '0; issue_ps2 = '0; issue_payload = '0;
    prf_rdata1 = '0; prf_rdata2 = '0; wb_valid = '0; wb_pd = '0; wb_data = '0;
  endtask

  task automatic set_op(input int c, input int p1, input int p2, input logic [PL-1:0] pay);
    issue_valid[c] = 1; issue_use1[c] = 1; issue_use2[c] = 1;
    issue_ps1[c] = PW'(p1); issue_ps2[c] = PW'(p2); issue_payload[c] = pay;
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin m_vld[c] = 0; m_op1[c] = 0; m_op2[c] = 0; m_pay[c] = 0; end
    idle_inputs(); fu_ready = '1; rst_n = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("rst_op1[%0d]", c), fu_op1[c], 32'd0);
      chk($sformatf("rst_pay[%0d]", c), fu_payload[c], 32'd0);
    end
    rst_n = 1;

    // Basic read on ch0
    set_op(0, 5, 9, 32'hA0A0_0001); prf_rdata1[0] = 32'h11; prf_rdata2[0] = 32'h22;
    cycle();
    chk("basic_op1", fu_op1[0], 32'h11);
    chk("basic_op2", fu_op2[0], 32'h22);
    idle_inputs(); cycle();

    // Bypass on ch1: single port 2, then ports 0 and 2 both match
    set_op(1, 12, 3, 32'hB1); prf_rdata1[1] = 0; prf_rdata2[1] = 32'h33;
    wb_valid[2] = 1; wb_pd[2] = 12; wb_data[2] = 32'hDEAD;
    cycle();
    chk("bypass_p2", fu_op1[1], 32'hDEAD);
    wb_valid[0] = 1; wb_pd[0] = 12; wb_data[0] = 32'hBEEF;
    cycle();
    chk("bypass_low_wins", fu_op1[1], 32'hBEEF);
    idle_inputs(); cycle();

    // Zero register and unused source ignore PRF data
    set_op(0, 0, 7, 32'hC0); issue_use2[0] = 0;
    prf_rdata1[0] = 32'hFFFF_FFFF; prf_rdata2[0] = 32'h1234_5678;
    wb_valid[1] = 1; wb_pd[1] = 7; wb_data[1] = 32'h5555;
    cycle();
    chk("zero_op1", fu_op1[0], 32'd0);
    chk("unused_op2", fu_op2[0], 32'd0);
    idle_inputs(); cycle();

    // Stall on ch2 while ch0 streams 4 ops
    fu_ready = '1; fu_ready[2] = 0;
    set_op(2, 20, 21, 32'hC2_0001); prf_rdata1[2] = 32'h2020; prf_rdata2[2] = 32'h2121;
    cycle();
    for (int k = 0; k < 4; k++) begin
      set_op(0, 30 + k, 40 + k, PL'(32'hD000 + k));
      prf_rdata1[0] = XL'(32'h300 + k); prf_rdata2[0] = XL'(32'h400 + k);
      set_op(2, 50, 51, 32'hC2_0BAD); prf_rdata1[2] = 32'hBAD0; prf_rdata2[2] = 32'hBAD1;
      if (k == 3) begin
        fu_ready[2] = 1; issue_payload[2] = 32'hC2_0002;
      end
      cycle();
      chk("stream_payload", fu_payload[0], 32'hD000 + 32'(k));
      if (k < 3) chk("stall_hold", fu_op1[2], 32'h2020);
    end
    chk("no_bubble_payload", fu_payload[2], 32'hC2_0002);
    idle_inputs();

    // Flush with everything stalled and a fresh op offered on every channel
    fu_ready = '0;
    for (int c = 0; c < NC; c++) set_op(c, 60 + c, 61 + c, PL'(32'hE000 + c));
    cycle();
    for (int c = 0; c < NC; c++) set_op(c, 70 + c, 71 + c, PL'(32'hF000 + c));
    flush = 1;
    cycle();
    chk("flush_clear", 32'(fu_valid), 32'd0);
    idle_inputs(); cycle();
    chk("flush_no_op", 32'(fu_valid), 32'd0);

    // Reset mid-stream with a held op
    set_op(1, 8, 9, 32'h77); prf_rdata1[1] = 32'h88; cycle();
    rst_n = 0; set_op(0, 10, 11, 32'h99); cycle();
    chk("midrst_valid", 32'(fu_valid), 32'd0);
    chk("midrst_op1", fu_op1[1], 32'd0);
    rst_n = 1; cycle();
    chk("after_rst_valid0", 32'(fu_valid[0]), 32'd1);

    // Randomized run
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      rst_n = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 19) == 0);
      for (int c = 0; c < NC; c++) begin
        issue_valid[c] = 1'($urandom_range(0, 3) != 0);
        issue_use1[c] = 1'($urandom); issue_use2[c] = 1'($urandom);
        issue_ps1[c] = PW'($urandom_range(0, 7)); issue_ps2[c] = PW'($urandom_range(0, 7));
        issue_payload[c] = $urandom; prf_rdata1[c] = $urandom; prf_rdata2[c] = $urandom;
        fu_ready[c] = 1'($urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < NW; i++) begin
        wb_valid[i] = 1'($urandom); wb_pd[i] = PW'($urandom_range(0, 7)); wb_data[i] = $urandom;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/operand_read_stage.md
# operand_read_stage

Parametrised register-read stage between the reservation stations and the functional units. It accepts up to NUM_CH issued micro-ops per cycle and drives the physical register file read ports. It bypasses same-cycle writeback results and zero-register reads, then latches the operands into a one-entry, per-channel output register with a valid/ready handshake toward each FU. It supersedes the fixed three-channel, purely combinational read path with a pipelined, stallable, flushable stage.

## Interface
Parameters:
- NUM_CH, 3, number of issue channels (ALU, branch, LSU by default).
- NUM_WB, 3, number of writeback/broadcast ports.
- PREG_W, 7, physical register index width.
- XLEN, 32, data width.
- PAYLOAD_W, 32, opaque per-op payload (opcode, imm, ROB tag) carried alongside the operands.

Ports (all multi-channel ports are packed [NUM_CH-1:0] of the stated element width):
- Clocking and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  kill all in-flight ops (mispredict or recovery).
- issue_valid  in  NUM_CH  op offered on the channel.
- issue_ready  out  NUM_CH  stage can accept the op on the channel.
- issue_ps1, issue_ps2  in  NUM_CH×PREG_W  source physical registers.
- issue_use1, issue_use2  in  NUM_CH  the source is actually consumed.
- issue_payload  in  NUM_CH×PAYLOAD_W  carried through unchanged.
- prf_re1, prf_re2  out  NUM_CH  PRF read enables.
- prf_raddr1, prf_raddr2  out  NUM_CH×PREG_W  PRF read addresses.
- prf_rdata1, prf_rdata2  in  NUM_CH×XLEN  PRF read data, combinational, same cycle.
- wb_valid  in  NUM_WB  writeback valid.
- wb_pd  in  NUM_WB×PREG_W  writeback destination.
- wb_data  in  NUM_WB×XLEN  writeback value.
- fu_valid  out  NUM_CH  operands valid to the FU.
- fu_ready  in  NUM_CH  FU accepts.
- fu_op1, fu_op2  out  NUM_CH×XLEN  resolved operands.
- fu_payload  out  NUM_CH×PAYLOAD_W  latched payload.

## Operation
- Accept on channel c when issue_valid[c] && issue_ready[c] && !flush.
- issue_ready[c] = !fu_valid[c] || fu_ready[c]. It is combinational and independent of issue_valid.
- prf_reN[c] = issue_valid[c] && issue_useN[c] && (issue_psN[c] != 0).
- prf_raddrN[c] = issue_psN[c] when the read is enabled, else 0.
- Operand resolution for each source, first match wins:
  1. Unused source, or psN == 0: operand is 0.
  2. Bypass: a valid writeback with wb_pd == psN supplies wb_data. The lowest-index matching port wins.
  3. Otherwise the operand is prf_rdataN.
- Bypass covers the cycle the PRF is written and does not yet show the value. A held (stalled) entry is never re-resolved.
- Output register per channel:
  - On accept, load fu_op1, fu_op2 and fu_payload, and set fu_valid.
  - Else, if fu_ready, clear fu_valid.
  - Else, hold all fields.
- Channels are fully independent; a stall on one channel never blocks another.
- flush has priority over everything except reset. All fu_valid clear at the next edge, and any op offered in the flush cycle is dropped.
- When the PRF is not read, its read-data inputs are ignored.

## Timing
- Latency: an op accepted at edge T presents on fu_* during cycle T+1.
- Throughput: one op per channel per cycle while fu_ready stays high.
- Reset (rst_n low at an edge): fu_valid = 0, fu_op1 = fu_op2 = 0, fu_payload = 0.
  - During reset, issue_ready follows its formula from the cleared fu_valid, so it reads 1. Accepts are suppressed.
  - Reset mid-stall discards the held op.
- Simultaneous accept and FU handshake on the same channel: the new op replaces the old one and fu_valid stays 1.
- Flush while stalled: the entry is dropped at the next edge and issue_ready = 1 afterwards.
- A writeback to the same register on two ports in one cycle is resolved by the lowest index; this is an upstream error but the behaviour is defined.
- No state other than the NUM_CH output registers; no internal combinational loops from fu_ready to issue_valid.

## Test plan
- Basic read:
  - Stimulus: ch0 issues ps1=5, ps2=9 with PRF returning 0x11 and 0x22; fu_ready=1.
  - Response: at T+1, fu_valid[0]=1, op1=0x11, op2=0x22, payload echoed, prf_re1/prf_re2=1.
- Bypass:
  - Stimulus: ch1 issues ps1=12 while wb_valid[2]=1, wb_pd[2]=12, wb_data[2]=0xDEAD; PRF returns a stale 0.
  - Response: fu_op1[1]=0xDEAD. With wb ports 0 and 2 both matching, port 0's data wins.
- Zero and unused sources:
  - Stimulus: ps1=0 with use1=1, and use2=0.
  - Response: prf_re1=prf_re2=0, op1=op2=0, regardless of prf_rdata.
- Stall and back-to-back:
  - Stimulus: ch2 fu_ready=0 for 3 cycles after an accept, while ch0 streams 4 ops.
  - Response: ch2 holds its operands and has issue_ready=0. ch0 delivers 4 ops in 4 consecutive cycles. When fu_ready rises together with a new issue on ch2, the new op appears the next cycle with no bubble.
- Flush:
  - Stimulus: all channels valid and stalled; flush=1 for one cycle with issue_valid=1 on all channels.
  - Response: all fu_valid=0 next cycle; no op from the flush cycle appears.
- Reset:
  - Stimulus: rst_n=0 for one edge mid-stream.
  - Response: all outputs are 0 after that edge; normal operation resumes on the first edge with rst_n=1.
